// File: rtl/sc_rand_arbiter_pkg.sv
// rtl/sc_rand_arbiter_pkg.sv - shared types, constants and shifter step function
// Purpose : FSM state encoding, shifter width/seed and the 8-bit feedback step.
// Ports   : none (package).
package sc_rand_arbiter_pkg;

  localparam int unsigned RAND_WIDTH = 8;
  localparam logic [RAND_WIDTH-1:0] RAND_SEED_DEFAULT = 8'h81;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

  // One shift-left step with feedback r[1]^r[3]^r[5]^r[7] entering at bit 0.
  function automatic logic [RAND_WIDTH-1:0] rand_next(input logic [RAND_WIDTH-1:0] r);
    return {r[6:0], r[1] ^ r[3] ^ r[5] ^ r[7]};
  endfunction

endpackage

// File: rtl/sc_rand_arbiter_if.sv
// rtl/sc_rand_arbiter_if.sv - consumer-side bundle of the random arbiter
// Purpose : groups request/ack, delivered data, seed load and idle-run controls.
// Ports   : master = consumer side (drives req/seed/idle run), slave = arbiter.
interface sc_rand_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import sc_rand_arbiter_pkg::*;

  logic [NUM_REQ-1:0]    SC_RandARB_req_InBUS;
  logic [NUM_REQ-1:0]    SC_RandARB_ack_OutBUS;
  logic [RAND_WIDTH-1:0] SC_RandARB_data_OutBUS;
  logic                  SC_RandARB_seedLoad_In;
  logic [RAND_WIDTH-1:0] SC_RandARB_seed_InBUS;
  logic                  SC_RandARB_idleRun_In;
  logic                  SC_RandARB_busy_Out;

  modport master (
    output SC_RandARB_req_InBUS, SC_RandARB_seedLoad_In, SC_RandARB_seed_InBUS,
           SC_RandARB_idleRun_In,
    input  SC_RandARB_ack_OutBUS, SC_RandARB_data_OutBUS, SC_RandARB_busy_Out
  );

  modport slave (
    input  SC_RandARB_req_InBUS, SC_RandARB_seedLoad_In, SC_RandARB_seed_InBUS,
           SC_RandARB_idleRun_In,
    output SC_RandARB_ack_OutBUS, SC_RandARB_data_OutBUS, SC_RandARB_busy_Out
  );

endinterface

// File: rtl/sc_rand_lfsr8.sv
// rtl/sc_rand_lfsr8.sv - 8-bit random shifter with step enable and seed load
// Purpose : holds the shared shifter; load wins over step; zero seed becomes default seed.
// Ports   : clk, rst_n (async active-low), step, load, seed[7:0] in; q[7:0] out.
module sc_rand_lfsr8
  import sc_rand_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  load,
  input  logic [RAND_WIDTH-1:0] seed,
  output logic [RAND_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RAND_SEED_DEFAULT;
    end else if (load) begin
      // An all-zero state never leaves zero, so substitute the default seed.
      q <= (seed == '0) ? RAND_SEED_DEFAULT : seed;
    end else if (step) begin
      q <= rand_next(q);
    end
  end

endmodule

// File: rtl/sc_rand_arbiter.sv
// rtl/sc_rand_arbiter.sv - round-robin sharing of the random shifter among consumers
// Purpose : grants one requester at a time, advances the shifter STEPS_PER_GRANT times,
//           then pulses that requester's ack with the fresh byte.
// Ports   : SC_RandARB_CLOCK_50 clock, SC_RandARB_RESET_InLow async active-low reset,
//           bus (slave modport): req/ack, data, seed load/value, idle run, busy.
module sc_rand_arbiter
  import sc_rand_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int STEPS_PER_GRANT = 8
) (
  input  logic                SC_RandARB_CLOCK_50,
  input  logic                SC_RandARB_RESET_InLow,
  sc_rand_arbiter_if.slave    bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LAST_STEP = 4'(STEPS_PER_GRANT - 1);

  logic clk;
  logic rst_n;
  assign clk   = SC_RandARB_CLOCK_50;
  assign rst_n = SC_RandARB_RESET_InLow;

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      grant;
  logic [3:0]            cnt;
  logic [NUM_REQ-1:0]    ack;
  logic [RAND_WIDTH-1:0] data;
  logic                  busy;
  logic [RAND_WIDTH-1:0] shifter;
  logic                  shift_step;

  logic [IDX_W-1:0]      next_idx;
  logic                  found;
  int                    cand;

  // Round-robin search: first set request starting just after the last grant.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    cand     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && bus.SC_RandARB_req_InBUS[cand]) begin
        found    = 1'b1;
        next_idx = IDX_W'(cand);
      end
    end
  end

  // The shifter holds still in DELIVER so the delivered byte is exactly the stepped value.
  assign shift_step = (state == ST_STEP) || ((state == ST_IDLE) && bus.SC_RandARB_idleRun_In);

  sc_rand_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (shift_step),
    .load  (bus.SC_RandARB_seedLoad_In),
    .seed  (bus.SC_RandARB_seed_InBUS),
    .q     (shifter)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= IDX_W'(NUM_REQ - 1);
      grant <= '0;
      cnt   <= '0;
      ack   <= '0;
      data  <= '0;
      busy  <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant <= next_idx;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (bus.SC_RandARB_seedLoad_In) begin
            // Restart the full step run from the freshly loaded seed.
            cnt <= '0;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_STEP) state <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          // Captures the pre-load value if a seed load lands in this cycle.
          ack   <= NUM_REQ'(1) << grant;
          data  <= shifter;
          ptr   <= grant;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.SC_RandARB_ack_OutBUS  = ack;
  assign bus.SC_RandARB_data_OutBUS = data;
  assign bus.SC_RandARB_busy_Out    = busy;

endmodule
